// File: rtl/am_demodulator.sv
// am_demodulator: AM envelope detector with block-average DC (carrier level) removal.
// I/Q magnitude via alpha-max-plus-beta-min approximation, 4-stage valid-qualified pipeline.
module am_demodulator #(
    parameter int unsigned AVG_LOG2 = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic signed [11:0] i_am_i,
    input  logic signed [11:0] i_am_q,
    output logic               o_valid,
    output logic signed [11:0] o_baseband,
    output logic        [11:0] o_magnitude,
    output logic        [11:0] o_dc_level,
    output logic               o_locked
);

    localparam int unsigned ACC_W = 12 + AVG_LOG2;

    // Absolute value saturated to 11 bits; -2048 maps to 2047.
    function automatic logic [10:0] abs_sat(input logic signed [11:0] x);
        logic [11:0] n;
        if (!x[11]) return x[10:0];
        if (x[10:0] == '0) return '1;
        n = 12'(-x);
        return n[10:0];
    endfunction

    logic              s1_valid;
    logic [10:0]       s1_ai;
    logic [10:0]       s1_aq;
    logic              s2_valid;
    logic [10:0]       s2_mx;
    logic [10:0]       s2_mn;
    logic              s3_valid;
    logic [11:0]       s3_mag;
    logic [11:0]       mag_c;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [AVG_LOG2-1:0] cnt;
    logic signed [12:0] diff;
    logic signed [11:0] bb_sat;

    // S1: rectify both components
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_ai    <= '0;
            s1_aq    <= '0;
        end else if (!i_enable) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_ai <= abs_sat(i_am_i);
                s1_aq <= abs_sat(i_am_q);
            end
        end
    end

    // S2: sort into larger and smaller component
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_valid <= 1'b0;
            s2_mx    <= '0;
            s2_mn    <= '0;
        end else if (!i_enable) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mx <= (s1_ai >= s1_aq) ? s1_ai : s1_aq;
                s2_mn <= (s1_ai >= s1_aq) ? s1_aq : s1_ai;
            end
        end
    end

    // Magnitude approximation: 15/16*max + 15/32*min with floor shifts
    always_comb begin
        mag_c = 12'(s2_mx) - 12'(s2_mx >> 4) + 12'(s2_mn >> 1) - 12'(s2_mn >> 5);
    end

    // S3: register magnitude
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s3_valid <= 1'b0;
            s3_mag   <= '0;
        end else if (!i_enable) begin
            s3_valid <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) s3_mag <= mag_c;
        end
    end

    // Running block sum and saturated DC-removed sample
    always_comb begin
        acc_sum = acc + {{AVG_LOG2{1'b0}}, s3_mag};
        diff    = $signed({1'b0, s3_mag}) - $signed({1'b0, o_dc_level});
        if (diff > 13'sd2047)
            bb_sat = 12'sd2047;
        else if (diff < -13'sd2048)
            bb_sat = -12'sd2048;
        else
            bb_sat = diff[11:0];
    end

    // DC estimator: block average over 2^AVG_LOG2 valid magnitudes
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            o_locked   <= 1'b0;
            o_dc_level <= '0;
        end else if (!i_enable) begin
            acc      <= '0;
            cnt      <= '0;
            o_locked <= 1'b0;
        end else if (s3_valid) begin
            if (cnt == '1) begin
                o_dc_level <= acc_sum[AVG_LOG2 +: 12];
                acc        <= '0;
                cnt        <= '0;
                o_locked   <= 1'b1;
            end else begin
                acc <= acc_sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // S4: output register; the block's last sample still sees the previous DC and lock state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid     <= 1'b0;
            o_baseband  <= '0;
            o_magnitude <= '0;
        end else if (!i_enable) begin
            o_valid    <= 1'b0;
            o_baseband <= '0;
        end else begin
            o_valid <= s3_valid && o_locked;
            if (s3_valid) begin
                o_magnitude <= s3_mag;
                if (o_locked) o_baseband <= bb_sat;
            end
        end
    end

endmodule

// File: tb/tb_am_demodulator.sv
// tb_am_demodulator: directed tests for am_demodulator with AVG_LOG2 = 4 (16-sample DC blocks).
module tb_am_demodulator;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_enable = 1'b0;
    logic               i_valid = 1'b0;
    logic signed [11:0] i_am_i = '0;
    logic signed [11:0] i_am_q = '0;
    logic               o_valid;
    logic signed [11:0] o_baseband;
    logic        [11:0] o_magnitude;
    logic        [11:0] o_dc_level;
    logic               o_locked;

    int n_cmp = 0;
    int n_err = 0;

    am_demodulator #(.AVG_LOG2(4)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_enable(i_enable),
        .i_valid(i_valid),
        .i_am_i(i_am_i),
        .i_am_q(i_am_q),
        .o_valid(o_valid),
        .o_baseband(o_baseband),
        .o_magnitude(o_magnitude),
        .o_dc_level(o_dc_level),
        .o_locked(o_locked)
    );

    always #5 i_clk = ~i_clk;

    // One clock edge, then settle before sampling outputs
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        tick();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n  = 1'b0;
        i_enable = 1'b1;
        i_valid  = 1'b1;
        i_am_i   = 12'sd1024;
        i_am_q   = 12'sd0;
        tick();
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0d expected 0", o_valid); end
        n_cmp++; if (o_locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %0d expected 0", o_locked); end
        n_cmp++; if (o_baseband !== 12'sd0) begin n_err++; $display("FAIL reset_baseband: got %0d expected 0", o_baseband); end
        n_cmp++; if (o_magnitude !== 12'd0) begin n_err++; $display("FAIL reset_magnitude: got %0d expected 0", o_magnitude); end
        n_cmp++; if (o_dc_level !== 12'd0) begin n_err++; $display("FAIL reset_dc: got %0d expected 0", o_dc_level); end
    endtask

    // Constant I=1024,Q=0 from reset: mag 960 at edge 4, lock at edge 19, valid from edge 20
    task automatic test_lock_constant(input string tag);
        int exp_mag;
        int exp_dc;
        i_rst_n  = 1'b1;
        i_enable = 1'b1;
        i_valid  = 1'b1;
        i_am_i   = 12'sd1024;
        i_am_q   = 12'sd0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp_mag = (k >= 4) ? 960 : 0;
            exp_dc  = (k >= 19) ? 960 : 0;
            n_cmp++; if (o_magnitude !== 12'(exp_mag)) begin n_err++; $display("FAIL %s_mag@%0d: got %0d expected %0d", tag, k, o_magnitude, exp_mag); end
            n_cmp++; if (o_locked !== (k >= 19)) begin n_err++; $display("FAIL %s_locked@%0d: got %0d expected %0d", tag, k, o_locked, (k >= 19)); end
            n_cmp++; if (o_dc_level !== 12'(exp_dc)) begin n_err++; $display("FAIL %s_dc@%0d: got %0d expected %0d", tag, k, o_dc_level, exp_dc); end
            n_cmp++; if (o_valid !== (k >= 20)) begin n_err++; $display("FAIL %s_valid@%0d: got %0d expected %0d", tag, k, o_valid, (k >= 20)); end
            n_cmp++; if (o_baseband !== 12'sd0) begin n_err++; $display("FAIL %s_bb@%0d: got %0d expected 0", tag, k, o_baseband); end
        end
    endtask

    // Back-to-back magnitude vectors, each result four edges after it is fed
    task automatic test_magnitudes();
        int vi [7] = '{512, -2048, 0, 2047, 0, 300, -1024};
        int vq [7] = '{512, 0, 0, 2047, -2048, -700, 0};
        int ve [7] = '{720, 1920, 0, 2880, 1920, 798, 960};
        apply_reset();
        i_enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 7) begin
                i_valid = 1'b1;
                i_am_i  = 12'(vi[c]);
                i_am_q  = 12'(vq[c]);
            end else begin
                i_valid = 1'b0;
            end
            tick();
            if (c >= 3) begin
                n_cmp++; if (o_magnitude !== 12'(ve[c-3])) begin n_err++; $display("FAIL mag_vec%0d: got %0d expected %0d", c - 3, o_magnitude, ve[c-3]); end
                n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mag_unlocked_valid%0d: got %0d expected 0", c - 3, o_valid); end
            end
        end
    endtask

    // Blocks of 1024 / full-scale / zero / full-scale drive baseband into both clamps
    task automatic test_baseband_clamp();
        apply_reset();
        i_enable = 1'b1;
        for (int k = 1; k <= 53; k++) begin
            i_valid = 1'b1;
            if (k - 1 < 16) begin
                i_am_i = 12'sd1024; i_am_q = 12'sd0;
            end else if (k - 1 < 32 || k - 1 >= 48) begin
                i_am_i = 12'sd2047; i_am_q = 12'sd2047;
            end else begin
                i_am_i = 12'sd0; i_am_q = 12'sd0;
            end
            tick();
            if (k == 20 || k == 35) begin
                n_cmp++; if (o_baseband !== 12'sd1920) begin n_err++; $display("FAIL bb_high@%0d: got %0d expected 1920", k, o_baseband); end
                n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL bb_high_valid@%0d: got %0d expected 1", k, o_valid); end
            end
            if (k == 35) begin
                n_cmp++; if (o_dc_level !== 12'd2880) begin n_err++; $display("FAIL dc_full@%0d: got %0d expected 2880", k, o_dc_level); end
            end
            if (k == 36 || k == 51) begin
                n_cmp++; if (o_baseband !== -12'sd2048) begin n_err++; $display("FAIL bb_clamp_neg@%0d: got %0d expected -2048", k, o_baseband); end
            end
            if (k == 51) begin
                n_cmp++; if (o_dc_level !== 12'd0) begin n_err++; $display("FAIL dc_zero@%0d: got %0d expected 0", k, o_dc_level); end
            end
            if (k == 52 || k == 53) begin
                n_cmp++; if (o_baseband !== 12'sd2047) begin n_err++; $display("FAIL bb_clamp_pos@%0d: got %0d expected 2047", k, o_baseband); end
            end
        end
    endtask

    // Irregular valid pattern after lock: o_valid mirrors it four edges later; block closes on 16th valid
    task automatic test_valid_gaps();
        logic [31:0] pat;
        int nv;
        int exp_dc;
        int exp_bb;
        logic ev;
        pat = 32'hB3A5_6C1F;
        nv  = 0;
        apply_reset();
        i_enable = 1'b1;
        i_valid  = 1'b1;
        i_am_i   = 12'sd1024;
        i_am_q   = 12'sd0;
        for (int k = 1; k <= 16; k++) tick();
        i_am_i = 12'sd512;
        i_am_q = 12'sd512;
        for (int j = 0; j < 35; j++) begin
            i_valid = (j < 32) ? pat[j] : 1'b0;
            tick();
            if (j >= 3) begin
                ev = pat[j-3];
                if (ev) nv++;
                exp_dc = (nv >= 16) ? 720 : 960;
                n_cmp++; if (o_valid !== ev) begin n_err++; $display("FAIL gap_valid%0d: got %0d expected %0d", j - 3, o_valid, ev); end
                n_cmp++; if (o_dc_level !== 12'(exp_dc)) begin n_err++; $display("FAIL gap_dc%0d: got %0d expected %0d", j - 3, o_dc_level, exp_dc); end
                if (ev) begin
                    exp_bb = (nv > 16) ? 0 : -240;
                    n_cmp++; if (o_baseband !== 12'(exp_bb)) begin n_err++; $display("FAIL gap_bb%0d: got %0d expected %0d", j - 3, o_baseband, exp_bb); end
                end
            end
        end
    endtask

    // Enable dropped with 9 samples of the second block accumulated, then relock on fresh data
    task automatic test_enable_drop();
        apply_reset();
        i_enable = 1'b1;
        i_valid  = 1'b1;
        i_am_i   = 12'sd1024;
        i_am_q   = 12'sd0;
        for (int k = 1; k <= 28; k++) tick();
        i_enable = 1'b0;
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL dis_valid: got %0d expected 0", o_valid); end
        n_cmp++; if (o_locked !== 1'b0) begin n_err++; $display("FAIL dis_locked: got %0d expected 0", o_locked); end
        n_cmp++; if (o_dc_level !== 12'd960) begin n_err++; $display("FAIL dis_dc: got %0d expected 960", o_dc_level); end
        n_cmp++; if (o_baseband !== 12'sd0) begin n_err++; $display("FAIL dis_bb: got %0d expected 0", o_baseband); end
        i_enable = 1'b1;
        i_am_i   = 12'sd512;
        i_am_q   = 12'sd512;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_cmp++; if (o_locked !== (k >= 19)) begin n_err++; $display("FAIL reen_locked@%0d: got %0d expected %0d", k, o_locked, (k >= 19)); end
            n_cmp++; if (o_dc_level !== ((k >= 19) ? 12'd720 : 12'd960)) begin n_err++; $display("FAIL reen_dc@%0d: got %0d expected %0d", k, o_dc_level, (k >= 19) ? 720 : 960); end
            n_cmp++; if (o_valid !== (k >= 20)) begin n_err++; $display("FAIL reen_valid@%0d: got %0d expected %0d", k, o_valid, (k >= 20)); end
        end
        n_cmp++; if (o_baseband !== 12'sd0) begin n_err++; $display("FAIL reen_bb: got %0d expected 0", o_baseband); end
    endtask

    // One-cycle reset mid-stream, then the power-up scenario must repeat exactly
    task automatic test_reset_mid();
        apply_reset();
        i_enable = 1'b1;
        i_valid  = 1'b1;
        i_am_i   = 12'sd1024;
        i_am_q   = 12'sd0;
        for (int k = 1; k <= 24; k++) tick();
        i_rst_n = 1'b0;
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %0d expected 0", o_valid); end
        n_cmp++; if (o_locked !== 1'b0) begin n_err++; $display("FAIL rstmid_locked: got %0d expected 0", o_locked); end
        n_cmp++; if (o_baseband !== 12'sd0) begin n_err++; $display("FAIL rstmid_bb: got %0d expected 0", o_baseband); end
        n_cmp++; if (o_magnitude !== 12'd0) begin n_err++; $display("FAIL rstmid_mag: got %0d expected 0", o_magnitude); end
        n_cmp++; if (o_dc_level !== 12'd0) begin n_err++; $display("FAIL rstmid_dc: got %0d expected 0", o_dc_level); end
        test_lock_constant("relock");
    endtask

    initial begin
        test_reset();
        test_lock_constant("lock");
        test_magnitudes();
        test_baseband_clamp();
        test_valid_gaps();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
